// File: rtl/risc16_control.sv
// risc16_control: multi-cycle control unit and PC owner for the RISC-16 core.
// Sequences FETCH -> DECODE -> (EXEC | MEM | WB) -> FETCH and drives the
// register-file, ALU and data-memory controls. Every output is registered.
// Optional build macro RISC16_MEM_TIMEOUT_EN adds a handshake wait limit
// (TIMEOUT_CYC) that halts the core and raises a sticky mem_err.
module risc16_control #(
    parameter logic [15:0] PC_RESET = 16'h0000
`ifdef RISC16_MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] pc,
    input  logic [15:0] reg_out1,
    input  logic [15:0] reg_out2,
    output logic        WE_rf,
    output logic [1:0]  MUX_tgt,
    output logic        MUX_rf,
    output logic [2:0]  rA,
    output logic [2:0]  rB,
    output logic [2:0]  rC,
    output logic [1:0]  alu_op,
    output logic        alu_src_imm,
    output logic [15:0] imm16,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        halted,
    output logic        mem_err
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      state;
    logic [15:0] ir;
    logic [2:0]  op;
    logic        wait_expired;

    assign op = ir[15:13];
    assign rA = ir[12:10];
    assign rB = ir[9:7];
    assign rC = ir[2:0];

    // Immediate: LUI takes the upper ten bits, everything else sign-extends IR[6:0].
    function automatic logic [15:0] imm_of(input logic [15:0] w);
        if (w[15:13] == OP_LUI) return {w[9:0], 6'b0};
        return {{9{w[6]}}, w[6:0]};
    endfunction

    // Static controls per opcode: {alu_op, alu_src_imm, MUX_rf, MUX_tgt}.
    function automatic logic [5:0] ctrl_of(input logic [2:0] opc);
        case (opc)
            OP_ADD:  return {2'b00, 1'b0, 1'b1, 2'b01};
            OP_ADDI: return {2'b00, 1'b1, 1'b0, 2'b01};
            OP_NAND: return {2'b01, 1'b0, 1'b1, 2'b01};
            OP_LUI:  return {2'b10, 1'b1, 1'b0, 2'b01};
            OP_SW:   return {2'b00, 1'b1, 1'b0, 2'b00};
            OP_LW:   return {2'b00, 1'b1, 1'b0, 2'b00};
            OP_BEQ:  return {2'b00, 1'b0, 1'b0, 2'b00};
            default: return {2'b00, 1'b0, 1'b0, 2'b10};
        endcase
    endfunction

`ifdef RISC16_MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;

    assign waiting      = (imem_req && !imem_ready) || (dmem_req && !dmem_ready);
    assign wait_expired = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Count consecutive stalled handshake cycles; any non-waiting cycle clears it.
    always_ff @(posedge clk) begin
        if (!rst_n)       wait_cnt <= '0;
        else if (waiting) wait_cnt <= wait_cnt + CNT_W'(1);
        else              wait_cnt <= '0;
    end

    // Sticky handshake-timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n)            mem_err <= 1'b0;
        else if (wait_expired) mem_err <= 1'b1;
    end
`else
    assign wait_expired = 1'b0;
    assign mem_err      = 1'b0;
`endif

    // Main sequencer: state, PC, IR and all registered control outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= PC_RESET;
            ir          <= '0;
            imm16       <= '0;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            WE_rf       <= 1'b0;
            MUX_tgt     <= '0;
            MUX_rf      <= 1'b0;
            alu_op      <= '0;
            alu_src_imm <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_req && imem_ready) begin
                        imem_req <= 1'b0;
                        ir       <= imem_rdata;
                        imm16    <= imm_of(imem_rdata);
                        {alu_op, alu_src_imm, MUX_rf, MUX_tgt} <= ctrl_of(imem_rdata[15:13]);
                        state    <= S_DECODE;
                    end else if (wait_expired) begin
                        imem_req <= 1'b0;
                        halted   <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: begin
                            dmem_req <= 1'b1;
                            dmem_we  <= (op == OP_SW);
                            state    <= S_MEM;
                        end
                        OP_BEQ: state <= S_EXEC;
                        OP_JALR: begin
                            if (ir[6:0] != 7'd0) begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end else begin
                                WE_rf <= 1'b1;
                                state <= S_WB;
                            end
                        end
                        default: begin
                            WE_rf <= 1'b1;
                            state <= S_WB;
                        end
                    endcase
                end
                S_EXEC: begin
                    pc       <= (reg_out1 == reg_out2) ? pc + 16'd1 + imm16 : pc + 16'd1;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (op == OP_SW) begin
                            pc       <= pc + 16'd1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            WE_rf <= 1'b1;
                            state <= S_WB;
                        end
                    end else if (wait_expired) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        halted   <= 1'b1;
                        state    <= S_HALT;
                    end
                end
                S_WB: begin
                    WE_rf    <= 1'b0;
                    pc       <= (op == OP_JALR) ? reg_out1 : pc + 16'd1;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc16_control.sv
// tb_risc16_control: random instruction stream against an opcode-level
// reference model; expectations are queued by the driver and consumed by a
// negedge monitor that watches fetch, memory and write-back activity.
module tb_risc16_control;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] pc;
    logic [15:0] reg_out1;
    logic [15:0] reg_out2;
    logic        WE_rf;
    logic [1:0]  MUX_tgt;
    logic        MUX_rf;
    logic [2:0]  rA;
    logic [2:0]  rB;
    logic [2:0]  rC;
    logic [1:0]  alu_op;
    logic        alu_src_imm;
    logic [15:0] imm16;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        halted;
    logic        mem_err;

    risc16_control dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc(pc), .reg_out1(reg_out1), .reg_out2(reg_out2),
        .WE_rf(WE_rf), .MUX_tgt(MUX_tgt), .MUX_rf(MUX_rf),
        .rA(rA), .rB(rB), .rC(rC),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm16(imm16),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .halted(halted), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
        logic [15:0] imm;
        logic [15:0] next_pc;
        logic [1:0]  tgt;
        logic [1:0]  aop;
        logic        src_imm;
        logic        mux_rf;
        logic        writes;
        logic        is_mem;
        logic        is_store;
        logic        halt;
        logic        chk_alu;
        int          mem_wait;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Architectural effect of one instruction, straight from the ISA rules.
    function automatic exp_t model(input logic [15:0] w, input logic [15:0] cur_pc,
                                   input logic [15:0] r1, input logic [15:0] r2);
        exp_t e;
        logic [15:0] sx;
        sx = {{9{w[6]}}, w[6:0]};
        e = '{ir: w, pc: cur_pc, imm: sx, next_pc: cur_pc + 16'd1, tgt: 2'b01, aop: 2'b00,
              src_imm: 1'b0, mux_rf: 1'b0, writes: 1'b1, is_mem: 1'b0, is_store: 1'b0,
              halt: 1'b0, chk_alu: 1'b1, mem_wait: 0};
        case (w[15:13])
            3'd0: e.mux_rf = 1'b1;
            3'd1: e.src_imm = 1'b1;
            3'd2: begin e.aop = 2'b01; e.mux_rf = 1'b1; end
            3'd3: begin e.aop = 2'b10; e.src_imm = 1'b1; e.imm = {w[9:0], 6'b0}; end
            3'd4: begin e.writes = 1'b0; e.is_mem = 1'b1; e.is_store = 1'b1; e.src_imm = 1'b1; end
            3'd5: begin e.tgt = 2'b00; e.is_mem = 1'b1; e.src_imm = 1'b1; end
            3'd6: begin
                e.writes = 1'b0;
                if (r1 == r2) e.next_pc = cur_pc + 16'd1 + sx;
            end
            default: begin
                e.chk_alu = 1'b0;
                if (w[6:0] != 7'd0) begin
                    e.halt = 1'b1; e.writes = 1'b0; e.next_pc = cur_pc;
                end else begin
                    e.tgt = 2'b10; e.next_pc = r1;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: pops an expectation at every accepted fetch and checks the
    // instruction's visible activity until the next one.
    exp_t cur;
    bit   have_cur = 0;
    int   wb_cnt = 0;
    int   mem_cnt = 0;
    bit   halt_seen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            have_cur = 0; wb_cnt = 0; mem_cnt = 0; halt_seen = 0;
        end else begin
            chk("req_exclusive", 16'(int'(imem_req) + int'(dmem_req) + int'(WE_rf) > 1), 16'd0);
            if (imem_req && imem_ready) begin
                if (have_cur) begin
                    chk("next_pc", pc, cur.next_pc);
                    chk("wb_count", 16'(wb_cnt), 16'(cur.writes));
                    if (cur.is_mem) chk("dmem_req_cycles", 16'(mem_cnt), 16'(cur.mem_wait + 1));
                end
                if (exp_q.size() == 0) begin
                    chk("queue_nonempty", 16'd0, 16'd1);
                    have_cur = 0;
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                    chk("fetch_pc", pc, cur.pc);
                end
                wb_cnt = 0; mem_cnt = 0;
            end
            if (WE_rf && have_cur) begin
                wb_cnt++;
                chk("wb_allowed", 16'(cur.writes), 16'd1);
                chk("wb_old_pc", pc, cur.pc);
                chk("wb_mux_tgt", 16'(MUX_tgt), 16'(cur.tgt));
                chk("wb_fields", {7'd0, rA, rB, rC}, {7'd0, cur.ir[12:10], cur.ir[9:7], cur.ir[2:0]});
                if (cur.chk_alu) begin
                    chk("wb_imm16", imm16, cur.imm);
                    chk("wb_alu", {12'd0, alu_op, alu_src_imm, MUX_rf},
                        {12'd0, cur.aop, cur.src_imm, cur.mux_rf});
                end
            end
            if (dmem_req && have_cur) begin
                mem_cnt++;
                chk("mem_allowed", 16'(cur.is_mem), 16'd1);
                chk("mem_we", 16'(dmem_we), 16'(cur.is_store));
                chk("mem_alu", {13'd0, alu_op, alu_src_imm}, {13'd0, 2'b00, 1'b1});
                chk("mem_imm16", imm16, cur.imm);
                chk("mem_pc", pc, cur.pc);
            end
            if (halted) begin
                chk("halt_quiet", {13'd0, imem_req, dmem_req, WE_rf}, 16'd0);
                if (!halt_seen && have_cur) begin
                    halt_seen = 1;
                    chk("halt_expected", 16'(cur.halt), 16'd1);
                    chk("halt_pc", pc, cur.pc);
                end
            end
        end
    end

    logic [15:0] pc_model;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        tick();
        tick();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_reqs", {12'd0, imem_req, dmem_req, WE_rf, halted}, 16'd0);
        chk("rst_ctrl", {9'd0, MUX_tgt, alu_op, alu_src_imm, MUX_rf, dmem_we, mem_err}, 16'd0);
        chk("rst_fields", {1'b0, imm16[5:0], rA, rB, rC}, 16'd0);
        chk("rst_imm16", imm16, 16'd0);
        exp_q.delete();
        pc_model = 16'h0000;
        rst_n = 1'b1;
    endtask

    task automatic wait_imem_req(output bit ok);
        int t = 0;
        while (!imem_req && t < 40) begin tick(); t++; end
        ok = imem_req;
        if (!ok) chk("imem_req_timeout", 16'd0, 16'd1);
    endtask

    task automatic wait_dmem_req(output bit ok);
        int t = 0;
        while (!dmem_req && t < 40) begin tick(); t++; end
        ok = dmem_req;
        if (!ok) chk("dmem_req_timeout", 16'd0, 16'd1);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:13] == 3'd7) begin
            if ($urandom_range(0, 24) != 0) w[6:0] = 7'd0;
            else if (w[6:0] == 7'd0) w[6:0] = 7'd1;
        end
        return w;
    endfunction

    // Issue one instruction: fetch handshake, optional dmem handshake.
    task automatic issue(input logic [15:0] w, input bit force_eq, output bit ok, output bit stop);
        logic [15:0] r1, r2;
        exp_t e;
        int d;
        stop = 0;
        wait_imem_req(ok);
        if (!ok) return;
        d = $urandom_range(0, 2);
        repeat (d) tick();
        r1 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        r2 = (force_eq || $urandom_range(0, 1) == 0) ? r1 : 16'($urandom);
        e = model(w, pc_model, r1, r2);
        e.mem_wait = $urandom_range(0, 3);
        exp_q.push_back(e);
        pc_model = e.next_pc;
        imem_rdata = w; reg_out1 = r1; reg_out2 = r2; imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0; imem_rdata = 16'($urandom);
        if (e.is_mem) begin
            wait_dmem_req(ok);
            if (!ok) return;
            repeat (e.mem_wait) tick();
            dmem_ready = 1'b1;
            tick();
            dmem_ready = 1'b0;
        end
        if (e.halt) begin
            int t = 0;
            while (!halted && t < 10) begin tick(); t++; end
            chk("halt_reached", 16'(halted), 16'd1);
            repeat (3) tick();
            stop = 1;
        end
    endtask

    initial begin
        bit ok, stop;
        int cyc;
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        imem_rdata = '0; reg_out1 = '0; reg_out2 = '0;
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            // ADDI r1,r0,-1, then BEQ -2, LW r2,r1,5 and JALR r7,r3 as fixed openers.
            if (ep == 0) begin
                issue(16'h247F, 1'b0, ok, stop);
                issue({3'd6, 3'd1, 3'd1, 7'h7E}, 1'b1, ok, stop);
                issue({3'd5, 3'd2, 3'd1, 7'd5}, 1'b0, ok, stop);
                issue({3'd7, 3'd7, 3'd3, 7'd0}, 1'b0, ok, stop);
            end
            for (int i = 0; i < 60; i++) begin
                issue(rand_instr(), 1'b0, ok, stop);
                if (!ok || stop) break;
            end
        end
        // Explicit halting JALR.
        do_reset();
        issue({3'd7, 3'd1, 3'd2, 7'd1}, 1'b0, ok, stop);
        // Reset while a load is stalled on dmem_ready.
        do_reset();
        wait_imem_req(ok);
        imem_rdata = {3'd5, 3'd2, 3'd1, 7'd5};
        exp_q.push_back(model(imem_rdata, pc_model, reg_out1, reg_out2));
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        wait_dmem_req(ok);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_pc", pc, 16'h0000);
        chk("midrst_reqs", {13'd0, imem_req, dmem_req, WE_rf}, 16'd0);
        rst_n = 1'b1;
        exp_q.delete();
`ifdef RISC16_MEM_TIMEOUT_EN
        // Fetch never acknowledged: halt with mem_err after 16 wait cycles.
        do_reset();
        cyc = 0;
        for (int t = 0; t < 40 && !halted; t++) begin
            if (imem_req) cyc++;
            tick();
        end
        chk("timeout_cycles", 16'(cyc), 16'd16);
        chk("timeout_flags", {14'd0, mem_err, halted}, 16'd3);
`else
        cyc = 0;
        repeat (20) tick();
        chk("no_timeout_flags", {14'd0, mem_err, halted}, 16'd0);
`endif
        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
